// File: rtl/stg_seq.sv
// Multi-cycle instruction sequencer: IF -> ID -> EX -> (LS) -> WB.
// HALT and ERR are terminal states. IF and LS waits are bounded by TIMEOUT.
module stg_seq #(
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst_n,
  input  logic                 i_ifu_valid,
  input  logic                 i_idu_valid,
  input  logic                 i_ctr_ram_wr_en,
  input  logic                 i_ctr_ld,
  input  logic                 i_ctr_reg_wr_en,
  input  logic                 i_ctr_halt,
  input  logic                 i_lsu_ack,
  output logic                 o_ifu_req,
  output logic                 o_idu_ready,
  output logic                 o_exu_ready,
  output logic                 o_lsu_req,
  output logic                 o_gpr_wr_en,
  output logic                 o_pc_wr_en,
  output logic [2:0]           o_state,
  output logic [CNT_WIDTH-1:0] o_inst_cnt,
  output logic                 o_halt,
  output logic                 o_err
);
  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_LS   = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;
  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [2:0]           state, state_nxt;
  logic [WW-1:0]        wait_cnt, wait_nxt;
  logic                 lat_ld, lat_st, lat_rw;
  logic [CNT_WIDTH-1:0] inst_cnt;
  logic                 last_wait;

  // wait_cnt holds cycles already waited, so this is the TIMEOUT-th waiting cycle
  assign last_wait = (wait_cnt == WW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      S_IF: begin
        if (i_ifu_valid)    state_nxt = S_ID;
        else if (last_wait) state_nxt = S_ERR;
        else                wait_nxt  = wait_cnt + 1'b1;
      end
      S_ID: begin
        if (i_idu_valid) state_nxt = i_ctr_halt ? S_HALT : S_EX;
      end
      S_EX: begin
        state_nxt = (lat_ld | lat_st) ? S_LS : S_WB;
        wait_nxt  = '0;
      end
      S_LS: begin
        if (i_lsu_ack)      state_nxt = S_WB;
        else if (last_wait) state_nxt = S_ERR;
        else                wait_nxt  = wait_cnt + 1'b1;
      end
      S_WB: begin
        state_nxt = S_IF;
        wait_nxt  = '0;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_ERR;  // ERR and the unused encoding 7
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state    <= S_IF;
      wait_cnt <= '0;
      lat_ld   <= 1'b0;
      lat_st   <= 1'b0;
      lat_rw   <= 1'b0;
      inst_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state == S_ID && i_idu_valid && !i_ctr_halt) begin
        lat_ld <= i_ctr_ld;
        lat_st <= i_ctr_ram_wr_en;
        lat_rw <= i_ctr_reg_wr_en;
      end
      if (state == S_WB) inst_cnt <= inst_cnt + 1'b1;
    end
  end

  assign o_ifu_req   = (state == S_IF);
  assign o_idu_ready = (state == S_ID);
  assign o_exu_ready = (state == S_EX);
  assign o_lsu_req   = (state == S_LS);
  assign o_pc_wr_en  = (state == S_WB);
  assign o_gpr_wr_en = (state == S_WB) & lat_rw;
  assign o_halt      = (state == S_HALT);
  assign o_err       = (state == S_ERR);
  assign o_state     = state;
  assign o_inst_cnt  = inst_cnt;
endmodule

// File: doc/stg_seq.md
STG_SEQ -- requirements
Module: stg_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum cycles spent in IF or LS waiting for a response.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of the retired-instruction counter.
REQ-003 i_sys_clk  in  1  the one clock; all state updates on its rising edge.
REQ-004 i_sys_rst_n  in  1  reset, asynchronous and active-low.
REQ-005 i_ifu_valid  in  1  fetched instruction is available.
REQ-006 i_idu_valid  in  1  decoder output is valid.
REQ-007 i_ctr_ram_wr_en  in  1  decoded store.
REQ-008 i_ctr_ld  in  1  decoded load (register write source is memory).
REQ-009 i_ctr_reg_wr_en  in  1  decoded GPR write enable.
REQ-010 i_ctr_halt  in  1  decoded EBREAK.
REQ-011 i_lsu_ack  in  1  memory access completed.
REQ-012 o_ifu_req  out  1  fetch request.
REQ-013 o_idu_ready  out  1  drives the decoder's i_sys_ready.
REQ-014 o_exu_ready  out  1  execute enable.
REQ-015 o_lsu_req  out  1  memory access request.
REQ-016 o_gpr_wr_en  out  1  gated GPR write strobe.
REQ-017 o_pc_wr_en  out  1  PC update strobe.
REQ-018 o_state  out  3  current state encoding.
REQ-019 o_inst_cnt  out  CNT_WIDTH  retired-instruction count.
REQ-020 o_halt, o_err  out  1 each  sticky status flags.

Function
REQ-021 States and encodings: IF=0, ID=1, EX=2, LS=3, WB=4, HALT=5, ERR=6; values 7 SHALL go to ERR.
REQ-022 Outputs SHALL be Moore-decoded from the state: o_ifu_req in IF; o_idu_ready in ID; o_exu_ready in EX; o_lsu_req in LS; o_pc_wr_en in WB; o_gpr_wr_en in WB only, and only if the latched reg_wr_en is 1.
REQ-023 IF: on i_ifu_valid=1 -> ID; otherwise stay.
REQ-024 ID: on i_idu_valid=1 and i_ctr_halt=1 -> HALT; on i_idu_valid=1 and i_ctr_halt=0 -> EX, latching i_ctr_ram_wr_en, i_ctr_ld and i_ctr_reg_wr_en; on i_idu_valid=0 -> stay.
REQ-025 EX: one cycle only; -> LS if latched ld or ram_wr_en, else -> WB.
REQ-026 LS: o_lsu_req held continuously until i_lsu_ack=1, then -> WB.
REQ-027 WB: one cycle; o_inst_cnt increments by 1 (wraps modulo 2^CNT_WIDTH); -> IF.
REQ-028 Minimum latency: 4 cycles per non-memory instruction, 5 per memory instruction (IF, ID, EX, LS, WB each 1 cycle when responses are immediate).
REQ-029 Wait counter: cleared on entry to IF or LS; increments each cycle spent waiting there. A response arriving on the TIMEOUT-th waiting cycle SHALL be accepted. No response by that cycle -> ERR.
REQ-030 HALT and ERR SHALL be absorbing until reset; all request/enable outputs are 0 there; o_halt=1 in HALT; o_err=1 in ERR.
REQ-031 If i_ctr_halt and a memory flag are both 1 in ID, halt SHALL take priority.
REQ-032 A store SHALL pass through WB with o_gpr_wr_en=0 and o_pc_wr_en=1.

Reset
REQ-033 Reset assertion SHALL immediately force state IF, o_inst_cnt=0, wait counter=0, latched controls=0, o_halt=0, o_err=0; o_ifu_req is therefore 1 during reset.
REQ-034 Reset asserted mid-LS SHALL drop o_lsu_req asynchronously, with no o_gpr_wr_en or o_pc_wr_en pulse.

Verification
REQ-035 ADDI stream with ifu_valid, idu_valid and lsu_ack tied 1 -> state sequence 0,1,2,4 repeating; o_inst_cnt=3 after 12 cycles; o_gpr_wr_en pulses once per 4 cycles.
REQ-036 Load with i_lsu_ack delayed 3 cycles -> LS lasts 4 cycles with o_lsu_req held; WB follows with o_gpr_wr_en=1.
REQ-037 Store (ram_wr_en=1, reg_wr_en=0) -> LS then WB with o_gpr_wr_en=0 and o_pc_wr_en=1.
REQ-038 TIMEOUT=4, i_ifu_valid held 0 -> ERR after 4 waiting cycles with o_err=1; variant where ifu_valid arrives on the 4th waiting cycle -> ID.
REQ-039 i_ctr_halt=1 with i_ctr_ld=1 in ID -> HALT next cycle, o_halt=1, o_inst_cnt frozen.
REQ-040 Reset asserted during LS -> all outputs at reset values the same cycle; after release the first fetch proceeds normally.
